// File: rtl/hist_lut_builder_pkg.sv
// hist_eq_pkg: shared types and default geometry for the histogram-equalization
// LUT builder.
//   - state_e            : frame sequencing states
//   - DATA_W_DEF         : default pixel width (bins = 2^DATA_W)
//   - PIXELS_LOG2_DEF    : default log2 of pixels per frame
//   - NBINS/NPIX/BIN_W   : geometry derived from the defaults
package hist_eq_pkg;

  localparam int DATA_W_DEF      = 8;
  localparam int PIXELS_LOG2_DEF = 16;

  localparam int NBINS = 2 ** DATA_W_DEF;
  localparam int NPIX  = 2 ** PIXELS_LOG2_DEF;
  localparam int BIN_W = PIXELS_LOG2_DEF + 1;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ACCUM,
    SCAN,
    DONE
  } state_e;

endpackage

// File: rtl/hist_lut_builder_if.sv
// hist_lut_builder_if: frame-control, pixel-stream and LUT-read signals of the
// histogram LUT builder.
//   master (frame source / LUT reader): drives start, pix_valid, pix_data, lut_addr
//   slave  (hist_lut_builder)         : drives pix_ready, lut_data, busy, done
interface hist_lut_builder_if #(
  parameter int DATA_W = 8
);

  logic              start;
  logic              pix_valid;
  logic [DATA_W-1:0] pix_data;
  logic              pix_ready;
  logic [DATA_W-1:0] lut_addr;
  logic [DATA_W-1:0] lut_data;
  logic              busy;
  logic              done;

  modport master (
    output start, pix_valid, pix_data, lut_addr,
    input  pix_ready, lut_data, busy, done
  );

  modport slave (
    input  start, pix_valid, pix_data, lut_addr,
    output pix_ready, lut_data, busy, done
  );

endinterface

// File: rtl/hist_lut_ram.sv
// hist_lut_ram: 2^DATA_W x DATA_W equalization LUT storage.
//   clk, rst    : clock, synchronous active-high reset (read register only)
//   wr_en_i     : write strobe (driven during SCAN)
//   wr_addr_i   : write address
//   wr_data_i   : write data
//   rd_addr_i   : read address, sampled every cycle
//   rd_data_o   : registered read data, one cycle after rd_addr_i
module hist_lut_ram #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [DATA_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [2**DATA_W];
  logic [DATA_W-1:0] rd_q;

  // Storage is left unreset; SCAN rewrites every entry before it is valid.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
    end else begin
      rd_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_q;

endmodule

// File: rtl/hist_lut_builder.sv
// hist_lut_builder: streams one 2^PIXELS_LOG2-pixel frame into a 2^DATA_W-bin
// histogram, prefix-sums it into a CDF and writes the equalization LUT.
//   clk, rst : clock, synchronous active-high reset
//   bus      : hist_lut_builder_if.slave
//              start     - begin a frame (honoured only in IDLE)
//              pix_valid/pix_data/pix_ready - pixel stream, ready only in ACCUM
//              lut_addr/lut_data - LUT read port, 1-cycle latency
//              busy      - high in every state except IDLE
//              done      - one-cycle pulse when the LUT is complete
module hist_lut_builder
  import hist_eq_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int PIXELS_LOG2 = PIXELS_LOG2_DEF
) (
  input  logic                clk,
  input  logic                rst,
  hist_lut_builder_if.slave   bus
);

  localparam int NUM_BINS = 2 ** DATA_W;
  localparam int BIN_BITS = PIXELS_LOG2 + 1;
  localparam int PROD_W   = BIN_BITS + DATA_W;

  state_e                 state_q, state_d;
  logic [DATA_W-1:0]      idx_q, idx_d;
  logic [PIXELS_LOG2-1:0] pix_cnt_q, pix_cnt_d;
  logic [BIN_BITS-1:0]    acc_q, acc_d;
  logic [BIN_BITS-1:0]    bin_q [NUM_BINS];

  logic                   hs;
  logic [BIN_BITS-1:0]    acc_next;
  logic                   lut_we;
  logic [DATA_W-1:0]      lut_wdata;

  // CDF count -> output level: cdf * (2^DATA_W - 1) / 2^PIXELS_LOG2, truncated.
  // cdf never exceeds 2^PIXELS_LOG2, so the result always fits DATA_W bits.
  function automatic logic [DATA_W-1:0] cdf_to_level(input logic [BIN_BITS-1:0] cdf);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(cdf) * PROD_W'(NUM_BINS - 1);
    return DATA_W'(prod >> PIXELS_LOG2);
  endfunction

  assign hs        = bus.pix_valid && (state_q == ACCUM);
  assign acc_next  = acc_q + bin_q[idx_q];
  assign lut_we    = (state_q == SCAN);
  assign lut_wdata = cdf_to_level(acc_next);

  assign bus.pix_ready = (state_q == ACCUM);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pix_cnt_d = pix_cnt_q;
    acc_d     = acc_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = CLEAR;
          idx_d   = '0;
        end
      end
      CLEAR: begin
        idx_d = idx_q + 1'b1;
        if (&idx_q) begin
          state_d   = ACCUM;
          pix_cnt_d = '0;
        end
      end
      ACCUM: begin
        if (hs) begin
          pix_cnt_d = pix_cnt_q + 1'b1;
          if (&pix_cnt_q) begin
            state_d = SCAN;
            acc_d   = '0;
            idx_d   = '0;
          end
        end
      end
      SCAN: begin
        acc_d = acc_next;
        idx_d = idx_q + 1'b1;
        if (&idx_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      pix_cnt_q <= '0;
      acc_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pix_cnt_q <= pix_cnt_d;
      acc_q     <= acc_d;
    end
  end

  // Bins are read and written in the same cycle, so back-to-back identical
  // pixels accumulate without any forwarding path. They are not reset: CLEAR
  // zeroes them at the start of every frame.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == CLEAR) begin
        bin_q[idx_q] <= '0;
      end else if (hs) begin
        bin_q[bus.pix_data] <= bin_q[bus.pix_data] + 1'b1;
      end
    end
  end

  hist_lut_ram #(
    .DATA_W (DATA_W)
  ) u_lut (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (lut_we),
    .wr_addr_i (idx_q),
    .wr_data_i (lut_wdata),
    .rd_addr_i (bus.lut_addr),
    .rd_data_o (bus.lut_data)
  );

endmodule
